// File: rtl/alu_wb_stage_pkg.sv
// Shared definitions for the ALU writeback stage: entry layout and default sizes.
package alu_wb_stage_pkg;
    localparam int kW        = 16;
    localparam int kRW       = 4;
    localparam int kWB_DEPTH = 2;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dest;
        logic        wen;
    } wb_entry_t;
endpackage

// File: rtl/alu_wb_stage_if.sv
// Execute-side offer, writeback handshake, flags and forwarding bundle.
interface alu_wb_stage_if #(
    parameter int W  = 16,
    parameter int RW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  alu_out;
    logic          alu_zero;
    logic          alu_equal;
    logic          alu_carryout;
    logic [RW-1:0] in_dest;
    logic          in_wen;
    logic          in_setc;
    logic          in_setf;
    logic          flush;
    logic          carryin;
    logic          zflag;
    logic          eflag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  wb_data;
    logic [RW-1:0] wb_dest;
    logic          wb_wen;
    logic          fwd_valid;
    logic [RW-1:0] fwd_dest;
    logic [W-1:0]  fwd_data;

    modport slave (
        input  in_valid, alu_out, alu_zero, alu_equal, alu_carryout,
               in_dest, in_wen, in_setc, in_setf, flush, out_ready,
        output in_ready, carryin, zflag, eflag, out_valid,
               wb_data, wb_dest, wb_wen, fwd_valid, fwd_dest, fwd_data
    );

    modport master (
        output in_valid, alu_out, alu_zero, alu_equal, alu_carryout,
               in_dest, in_wen, in_setc, in_setf, flush, out_ready,
        input  in_ready, carryin, zflag, eflag, out_valid,
               wb_data, wb_dest, wb_wen, fwd_valid, fwd_dest, fwd_data
    );
endinterface

// File: rtl/alu_wb_stage_wb_fifo.sv
// In-order buffer of writeback entries with head and newest-entry read ports.
module wb_fifo
    import alu_wb_stage_pkg::*;
#(
    parameter int DEPTH = kWB_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic      i_clk,
    input  logic      i_reset,
    input  logic      i_push,
    input  logic      i_pop,
    input  logic      i_flush,
    input  wb_entry_t i_din,
    output logic [AW:0] o_count,
    output wb_entry_t o_head,
    output wb_entry_t o_newest
);
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    wb_entry_t     r_mem [DEPTH];
    logic [AW-1:0] w_newest_idx;

    assign w_newest_idx = r_tail - AW'(1);
    assign o_count      = r_count;
    assign o_head       = r_mem[r_head];
    assign o_newest     = r_mem[w_newest_idx];

    // Storage is cleared on reset so the read ports show zero afterwards.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_din;
                r_tail        <= r_tail + AW'(1);
            end
            if (i_pop) r_head <= r_head + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: result FIFO, architectural carry/zero/equal flags,
// register-file handshake and newest-result forwarding.
module alu_wb_stage
    import alu_wb_stage_pkg::*;
#(
    parameter int DEPTH = kWB_DEPTH,
    parameter int W     = kW,
    parameter int RW    = kRW,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic i_clk,
    input  logic i_reset,
    alu_wb_stage_if.slave bus
);
    logic [AW:0] w_count;
    wb_entry_t   w_din;
    wb_entry_t   w_head;
    wb_entry_t   w_newest;
    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_accept;
    logic        w_drain;
    logic        r_carry;
    logic        r_zero;
    logic        r_equal;

    // Ready depends only on registered count; a drain while full does not free a slot until next cycle.
    assign w_in_ready  = (w_count < (AW+1)'(DEPTH));
    assign w_out_valid = (w_count != '0);
    assign w_accept    = bus.in_valid & w_in_ready & ~bus.flush;
    assign w_drain     = w_out_valid & bus.out_ready & ~bus.flush;

    assign w_din.data = 16'(bus.alu_out);
    assign w_din.dest = 4'(bus.in_dest);
    assign w_din.wen  = bus.in_wen;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_push   (w_accept),
        .i_pop    (w_drain),
        .i_flush  (bus.flush),
        .i_din    (w_din),
        .o_count  (w_count),
        .o_head   (w_head),
        .o_newest (w_newest)
    );

    // Flags commit at accept so carry-chained ops can issue back to back.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_equal <= 1'b0;
        end else if (w_accept) begin
            if (bus.in_setc) r_carry <= bus.alu_carryout;
            if (bus.in_setf) begin
                r_zero  <= bus.alu_zero;
                r_equal <= bus.alu_equal;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.carryin   = r_carry;
    assign bus.zflag     = r_zero;
    assign bus.eflag     = r_equal;
    assign bus.out_valid = w_out_valid;
    assign bus.wb_data   = W'(w_head.data);
    assign bus.wb_dest   = RW'(w_head.dest);
    assign bus.wb_wen    = w_head.wen & w_out_valid;
    assign bus.fwd_valid = w_newest.wen & w_out_valid;
    assign bus.fwd_dest  = RW'(w_newest.dest);
    assign bus.fwd_data  = W'(w_newest.data);
endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: directed scenarios plus randomized traffic.
module tb_alu_wb_stage;
    import alu_wb_stage_pkg::*;

    localparam int DEPTH = kWB_DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_wb_stage_if bus ();

    alu_wb_stage #(.DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: queue of buffered results plus three flag bits.
    wb_entry_t q[$];
    logic      m_c = 1'b0, m_z = 1'b0, m_e = 1'b0;
    int        n_tests = 0, n_fail = 0;
    bit        mon_en = 1'b0;

    bit        p_acc = 1'b0, p_rst = 1'b0;
    wb_entry_t p_ent;
    bit        p_setc, p_setf, p_co, p_zo, p_eq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the result of the previous cycle's offer is committed to the model first.
    task automatic step(input bit r, input bit v, input logic [15:0] d, input logic [3:0] dst,
                        input bit wen, input bit setc, input bit setf, input bit co, input bit zo,
                        input bit eq, input bit fl, input bit ordy, output bit acc);
        @(posedge clk);
        #1;
        if (p_rst) begin
            m_c = 1'b0; m_z = 1'b0; m_e = 1'b0;
        end else if (p_acc) begin
            q.push_back(p_ent);
            if (p_setc) m_c = p_co;
            if (p_setf) begin m_z = p_zo; m_e = p_eq; end
        end
        rst              = r;
        bus.in_valid     = v;
        bus.alu_out      = d;
        bus.in_dest      = dst;
        bus.in_wen       = wen;
        bus.in_setc      = setc;
        bus.in_setf      = setf;
        bus.alu_carryout = co;
        bus.alu_zero     = zo;
        bus.alu_equal    = eq;
        bus.flush        = fl;
        bus.out_ready    = ordy;
        acc    = !r && v && !fl && (q.size() < DEPTH);
        p_rst  = r;
        p_acc  = acc;
        p_ent  = '{data: d, dest: dst, wen: wen};
        p_setc = setc; p_setf = setf; p_co = co; p_zo = zo; p_eq = eq;
    endtask

    task automatic idle(input bit ordy);
        bit a;
        step(0, 0, 16'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, ordy, a);
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] dst, input bit wen, input bit ordy,
                         output bit acc);
        step(0, 1, d, dst, wen, 0, 0, 0, 0, 0, 0, ordy, acc);
    endtask

    task automatic chk_storage_clear(input string tag);
        chk({tag, "_wb_data"},  32'(bus.wb_data),  32'h0);
        chk({tag, "_wb_dest"},  32'(bus.wb_dest),  32'h0);
        chk({tag, "_fwd_data"}, 32'(bus.fwd_data), 32'h0);
        chk({tag, "_fwd_dest"}, 32'(bus.fwd_dest), 32'h0);
    endtask

    // Monitor: compares DUT outputs with the model mid-cycle, then retires the drained head.
    initial begin
        forever begin
            @(posedge clk);
            #4;
            if (mon_en) begin
                chk("in_ready",  32'(bus.in_ready),  32'(q.size() < DEPTH));
                chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
                chk("carryin",   32'(bus.carryin),   32'(m_c));
                chk("zflag",     32'(bus.zflag),     32'(m_z));
                chk("eflag",     32'(bus.eflag),     32'(m_e));
                if (q.size() > 0) begin
                    chk("wb_data",   32'(bus.wb_data),   32'(q[0].data));
                    chk("wb_dest",   32'(bus.wb_dest),   32'(q[0].dest));
                    chk("wb_wen",    32'(bus.wb_wen),    32'(q[0].wen));
                    chk("fwd_valid", 32'(bus.fwd_valid), 32'(q[$].wen));
                    chk("fwd_dest",  32'(bus.fwd_dest),  32'(q[$].dest));
                    chk("fwd_data",  32'(bus.fwd_data),  32'(q[$].data));
                end else begin
                    chk("wb_wen_empty",    32'(bus.wb_wen),    32'h0);
                    chk("fwd_valid_empty", 32'(bus.fwd_valid), 32'h0);
                end
                if (rst || bus.flush) q.delete();
                else if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        bit a;
        int tries;
        bus.in_valid = 0; bus.alu_out = '0; bus.alu_zero = 0; bus.alu_equal = 0;
        bus.alu_carryout = 0; bus.in_dest = '0; bus.in_wen = 0; bus.in_setc = 0;
        bus.in_setf = 0; bus.flush = 0; bus.out_ready = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
        mon_en = 1'b1;
        idle(0);
        chk_storage_clear("reset");

        // Single result passes straight through with OUT_READY high.
        offer(16'h0008, 4'd3, 1, 1, a);
        chk("single_accept", 32'(a), 32'h1);
        idle(1);
        idle(1);

        // Carry chain: set, hold across a non-setting op, then clear.
        step(0, 1, 16'h1111, 4'd1, 1, 1, 0, 1, 0, 0, 0, 1, a);
        step(0, 1, 16'h2222, 4'd2, 1, 0, 0, 0, 0, 0, 0, 1, a);
        step(0, 1, 16'h3333, 4'd3, 1, 1, 0, 0, 0, 0, 0, 1, a);
        idle(1);
        idle(1);

        // Back-pressure, then full-with-drain: third offer only lands after a slot frees.
        offer(16'h0001, 4'd1, 1, 0, a); chk("bp_acc1", 32'(a), 32'h1);
        offer(16'h0002, 4'd2, 1, 0, a); chk("bp_acc2", 32'(a), 32'h1);
        offer(16'h0003, 4'd3, 1, 0, a); chk("bp_held", 32'(a), 32'h0);
        offer(16'h0003, 4'd3, 1, 1, a); chk("full_drain_no_acc", 32'(a), 32'h0);
        tries = 0;
        do begin
            offer(16'h0003, 4'd3, 1, 1, a);
            tries++;
        end while (!a && tries < 8);
        chk("bp_acc3", 32'(a), 32'h1);
        repeat (4) idle(1);

        // Flush while full, with a flag-setting offer in the same cycle.
        offer(16'h0010, 4'd4, 1, 0, a);
        offer(16'h0020, 4'd6, 1, 0, a);
        step(0, 1, 16'h0000, 4'd7, 1, 1, 1, 1, 1, 1, 1, 1, a);
        chk("flush_no_acc", 32'(a), 32'h0);
        idle(1);
        idle(1);

        // Forwarding: newest same-dest entry wins; a WEN=0 newest entry hides forwarding.
        offer(16'h00AA, 4'd5, 1, 0, a);
        offer(16'h00BB, 4'd5, 1, 0, a);
        idle(0);
        chk("fwd_newest_data", 32'(bus.fwd_data), 32'h00BB);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, a);
        offer(16'h00CC, 4'd9, 0, 0, a);
        idle(0);
        chk("fwd_wen0", 32'(bus.fwd_valid), 32'h0);
        repeat (3) idle(1);

        // Reset mid-operation discards entries and clears storage.
        offer(16'h1234, 4'd8, 1, 0, a);
        step(0, 1, 16'h5678, 4'd9, 1, 1, 1, 1, 1, 1, 0, 0, a);
        step(1, 1, 16'h9ABC, 4'd2, 1, 0, 0, 0, 0, 0, 0, 1, a);
        idle(1);
        chk_storage_clear("midreset");

        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 16'($urandom),
                 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) != 0, a);
        end
        repeat (5) idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_wb_stage.md
# alu_wb_stage

Execute-to-writeback stage directly downstream of the ALU. Captures each accepted ALU result (OUT, ZERO, EQUAL, CARRYOUT) with its destination tag in a small in-order FIFO. Holds the architectural carry flag that drives the ALU's CARRYIN and the zero/equal branch flags. Presents results to the register-file write port under a valid/ready handshake, and exposes the newest buffered result for operand forwarding.

## Interface
Parameters:
- DEPTH, 2, number of buffered results; power of two, ≥2.
- W, 16, datapath width; matches ALU OUT.
- RW, 4, register index width; matches ALU INPUTD.

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-high reset.
- IN_VALID  in  1  execute stage offers a result this cycle.
- IN_READY  out  1  stage can accept; high iff count < DEPTH.
- ALU_OUT  in  W  ALU result.
- ALU_ZERO  in  1  ALU ZERO.
- ALU_EQUAL  in  1  ALU EQUAL.
- ALU_CARRYOUT  in  1  ALU CARRYOUT.
- IN_DEST  in  RW  destination register.
- IN_WEN  in  1  result writes the register file.
- IN_SETC  in  1  result updates the carry flag.
- IN_SETF  in  1  result updates ZFLAG/EFLAG.
- FLUSH  in  1  discard buffered entries and the same-cycle offer.
- CARRYIN  out  1  carry flag, wired to the ALU CARRYIN.
- ZFLAG  out  1  zero flag for branches.
- EFLAG  out  1  equal flag for branches.
- OUT_VALID  out  1  head entry valid (count > 0).
- OUT_READY  in  1  register file consumes the head this cycle.
- WB_DATA  out  W  head data.
- WB_DEST  out  RW  head destination.
- WB_WEN  out  1  head write enable, gated by OUT_VALID.
- FWD_VALID  out  1  newest entry valid and its WEN is set.
- FWD_DEST  out  RW  newest entry destination.
- FWD_DATA  out  W  newest entry data.

## Operation
- Accept = IN_VALID & IN_READY & !FLUSH. On accept:
  - push {ALU_OUT, IN_DEST, IN_WEN} at the tail;
  - if IN_SETC, CARRYIN <= ALU_CARRYOUT;
  - if IN_SETF, ZFLAG <= ALU_ZERO and EFLAG <= ALU_EQUAL.
- Flags commit at accept, not at writeback. This lets back-to-back carry-chained ops issue without a bubble.
- Drain = OUT_VALID & OUT_READY & !FLUSH. On drain, pop the head.
- Same-cycle accept and drain: count is unchanged and both pointers advance. This is legal whenever count < DEPTH.
- IN_READY is derived from the registered count only. At count == DEPTH, no accept occurs even if a drain happens that cycle; ready rises the next cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- FLUSH:
  - count <= 0 and head = tail;
  - the same-cycle offer is dropped and its flag updates are suppressed;
  - flags already committed are kept;
  - a same-cycle drain is also suppressed (OUT_READY is ignored).
- Forwarding:
  - FWD_* reflect entry tail-1 when count > 0;
  - FWD_VALID = (count > 0) & that entry's WEN;
  - the newest entry always wins, including over an older entry with the same destination;
  - forwarding is not combinational from ALU_* (no in-cycle bypass).
- IN_* are ignored while IN_VALID is low. OUT_READY is ignored while OUT_VALID is low.

## Timing
- Reset values: count 0, pointers 0, CARRYIN 0, ZFLAG 0, EFLAG 0, OUT_VALID 0, WB_WEN 0, FWD_VALID 0, IN_READY 1. WB_DATA, WB_DEST, FWD_DATA and FWD_DEST read 0, because storage is cleared on reset.
- RESET overrides FLUSH, accept and drain in the same cycle.
- Latency: an offer accepted at edge N is visible on WB_*/FWD_* and CARRYIN after edge N, i.e. in cycle N+1. There is no empty-FIFO bypass.
- Throughput: one result per cycle when OUT_READY is held high.
- All outputs are registered or decoded from registered state. There is no combinational path from IN_VALID/OUT_READY to IN_READY.
- Reset mid-operation discards all entries. The register file sees no further WB_WEN until new accepts occur.

## Structure
- Add to the shared definitions package:
  - typedef wb_entry_t {logic [15:0] data; logic [3:0] dest; logic wen;};
  - constant kWB_DEPTH = 2.
- Natural sub-module: wb_fifo. It is a parameterized DEPTH×wb_entry_t in-order buffer with push, pop, flush, count, and head/tail-1 read ports.
- alu_wb_stage wraps wb_fifo and adds the flag registers and the accept/drain gating.

## Test plan
- Reset, then offer ALU_OUT=16'h0008, DEST=3, WEN=1 with OUT_READY=1. Required: WB_DATA=16'h0008, WB_DEST=3, WB_WEN=1 one cycle later; count returns to 0; FWD_VALID pulses for one cycle.
- Carry chain: accept SETC=1 with CARRYOUT=1, then immediately accept a second op with SETC=0. Required: CARRYIN=1 in the cycle after the first accept and it stays 1; a third accept with SETC=1 and CARRYOUT=0 clears it.
- Back-pressure: OUT_READY=0, offer 3 results (16'h0001, 16'h0002, 16'h0003). Required: first two accepted and IN_READY=0 afterwards; third held. With OUT_READY=1, writebacks appear in order 1, 2, 3 with no loss.
- Full with simultaneous drain: at count=2, IN_VALID=1 and OUT_READY=1. Required: head popped, no accept that cycle, IN_READY=1 next cycle, offer accepted then.
- Flush: count=2 plus an offer with SETF=1 and ALU_ZERO=1 in the same cycle as FLUSH=1. Required: count=0, OUT_VALID=0, ZFLAG unchanged, no WB_WEN.
- Forwarding: buffer DEST=5 data 16'h00AA, then DEST=5 data 16'h00BB with OUT_READY=0. Required: FWD_DEST=5, FWD_DATA=16'h00BB; an entry with WEN=0 makes FWD_VALID=0.
